argmax_seq: RTL and testbench

Sequential argmax stage that consumes the relu start/done vector handshake at the output layer of the MLP. On start it snapshots a NUM_CLASSES vector of signed Q7.8 scores and scans it one element per clock. It then reports the winning class index and its score with a one-cycle done pulse. It is the receiving end of the vector/start/done interface that relu drives.

---
 rtl/argmax_seq.sv | 150 +++++++++++++++
 tb/tb_argmax_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq.sv
// -----------------------------------------------------------------------------
// argmax_seq
//   Sequential argmax over a vector of signed fixed-point scores.
//
//   This module receives the vector/start/done handshake that the relu stage
//   drives at the MLP output layer. An accepted start takes a snapshot of the
//   whole input vector. The module then scans the snapshot one element per
//   clock and reports the index and value of the largest element. Ties go to
//   the lowest index.
//
//   Ports
//     clk           rising-edge clock
//     reset         asynchronous, active-high; clears all state at once
//     start         scan request; honoured only while busy=0 (IDLE or DONE)
//     input_vector  NUM_CLASSES packed signed scores, element i at
//                   [i*FP_TOTAL_BITS +: FP_TOTAL_BITS] (element 0 in the LSBs)
//     class_idx     index of the maximum element (held until the next result)
//     max_value     value of the maximum element (held until the next result)
//     busy          high while a scan is in progress
//     done          one-cycle pulse; class_idx/max_value are valid
//
//   Timing: start sampled high at edge 0 gives done=1 in cycle NUM_CLASSES.
// -----------------------------------------------------------------------------
module argmax_seq #(
  parameter int NUM_CLASSES   = 4,
  parameter int FP_TOTAL_BITS = 16,
  parameter int FP_FRAC_BITS  = 8,
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NUM_CLASSES*FP_TOTAL_BITS-1:0]   input_vector,
  output logic [IDX_W-1:0]                       class_idx,
  output logic signed [FP_TOTAL_BITS-1:0]        max_value,
  output logic                                   busy,
  output logic                                   done
);

  // FP_FRAC_BITS only keeps the interface consistent with the rest of the
  // datapath. Ordering Q-format numbers of one format is a plain integer
  // compare. This empty block records the legal range of the parameter.
  if (FP_FRAC_BITS < 0 || FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_frac_bits_out_of_range
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic signed [FP_TOTAL_BITS-1:0] snap_q [NUM_CLASSES];
  logic signed [FP_TOTAL_BITS-1:0] snap_d [NUM_CLASSES];
  logic [IDX_W-1:0]                cnt_q, cnt_d;
  logic signed [FP_TOTAL_BITS-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                class_idx_q, class_idx_d;
  logic signed [FP_TOTAL_BITS-1:0] max_value_q, max_value_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_value_d = max_value_q;

    case (state_q)
      S_SCAN: begin
        cnt_d = cnt_q + IDX_W'(1);
        // Strictly greater only, so an equal later element never wins.
        if (snap_q[cnt_q] > best_val_q) begin
          best_val_d = snap_q[cnt_q];
          best_idx_d = cnt_q;
        end
        // The last element has been compared. Publish the final best. The
        // result registers do not change at any other point of a scan.
        if (cnt_q == IDX_W'(NUM_CLASSES - 1)) begin
          state_d     = S_DONE;
          class_idx_d = best_idx_d;
          max_value_d = best_val_d;
        end
      end

      default: begin
        // IDLE and DONE both accept a start. Accepting in DONE allows
        // back-to-back scans with no idle cycle between them.
        if (start) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            snap_d[i] = input_vector[i*FP_TOTAL_BITS +: FP_TOTAL_BITS];
          end
          best_val_d = input_vector[FP_TOTAL_BITS-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          if (NUM_CLASSES == 1) begin
            // A single element is already the answer.
            state_d     = S_DONE;
            class_idx_d = '0;
            max_value_d = input_vector[FP_TOTAL_BITS-1:0];
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // busy and done are registered decodes of the next state. They therefore
    // line up exactly with the state they describe.
    busy_d = (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= '0;
      end
      cnt_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_value_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_value_q <= max_value_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign class_idx = class_idx_q;
  assign max_value = max_value_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_argmax_seq.sv
// -----------------------------------------------------------------------------
// tb_argmax_seq
//   Directed and random stimulus for argmax_seq (default parameters).
//   A cycle-level reference model tracks what the outputs must be:
//     - when a scan was accepted and how many edges remain until done;
//     - the lowest-index maximum of the accepted snapshot;
//     - the last published result.
//   A compare process checks every DUT output against this model on every
//   cycle outside reset. Directed runs also check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_argmax_seq;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N*W-1:0]   input_vector;
  logic [1:0]       class_idx;
  logic signed [W-1:0] max_value;
  logic             busy;
  logic             done;

  argmax_seq #(
    .NUM_CLASSES  (N),
    .FP_TOTAL_BITS(W),
    .FP_FRAC_BITS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .input_vector(input_vector),
    .class_idx   (class_idx),
    .max_value   (max_value),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pack four scores with element 0 in the LSBs.
  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c,
                                        input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference: lowest-index maximum using plain signed integers.
  function automatic void ref_argmax(input logic [N*W-1:0] v, output int idx,
                                     output int val);
    logic signed [W-1:0] e;
    e   = v[W-1:0];
    idx = 0;
    val = e;
    for (int i = 1; i < N; i++) begin
      e = v[i*W +: W];
      if (int'(e) > val) begin
        val = e;
        idx = i;
      end
    end
  endfunction

  // ---------------- reference model ----------------
  int rem;        // edges still to go before the result appears
  int p_idx, p_val;
  int m_idx, m_val;
  bit m_busy, m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem = 0; m_idx = 0; m_val = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done = 1; m_idx = p_idx; m_val = p_val;
        end
      end else if (start) begin
        ref_argmax(input_vector, p_idx, p_val);
        rem = N - 1;
        if (rem == 0) begin
          m_done = 1; m_idx = p_idx; m_val = p_val;
        end
      end
      m_busy = (rem > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (cmp_en && !reset) begin
      check("cyc_done", done, m_done);
      check("cyc_busy", busy, m_busy);
      check("cyc_idx", class_idx, m_idx);
      check("cyc_val", max_value, m_val);
    end
  end

  // One scan: start for one cycle, scramble the inputs, then wait for done
  // (bounded). Checks latency, busy while waiting and the literal result.
  task automatic run(input string nm, input logic [N*W-1:0] v, input int eidx,
                     input int eval_);
    int lat;
    bit seen;
    @(negedge clk);
    input_vector = v;
    start = 1'b1;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      input_vector = {$urandom, $urandom};
      lat++;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy !== 1'b1) check({nm, "_busy"}, busy, 1);
    end
    check({nm, "_seen"}, seen, 1);
    check({nm, "_lat"}, lat, N);
    check({nm, "_idx"}, class_idx, eidx);
    check({nm, "_val"}, max_value, eval_);
  endtask

  initial begin
    int ridx, rval;
    int v[N];
    reset = 1'b1;
    start = 1'b0;
    input_vector = '0;
    repeat (2) @(negedge clk);
    check("rst_idx", class_idx, 0);
    check("rst_val", max_value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Hand vectors with literal expectations.
    run("hand", pk(128, -256, 0, 768), 3, 768);
    check("model_hand_idx", m_idx, 3);
    check("model_hand_val", m_val, 768);
    run("ties", pk(256, 256, -1, 256), 0, 256);
    run("allmin", pk(-32768, -32768, -32768, -32768), 0, -32768);
    check("model_min_val", m_val, -32768);
    run("neg", pk(-5, -3, -3, -256), 1, -3);
    check("model_neg_idx", m_idx, 1);
    run("maxpos", pk(-32768, 32767, 32767, 0), 1, 32767);

    // A start during a scan is ignored. A start in the done cycle is taken.
    @(negedge clk);
    input_vector = pk(128, -256, 0, 768); start = 1'b1;          // cycle 0
    @(negedge clk); start = 1'b0; input_vector = '0;             // cycle 1
    @(negedge clk); input_vector = pk(0, 0, 0, 1000); start = 1'b1; // cycle 2
    @(negedge clk); start = 1'b0;                                // cycle 3
    @(negedge clk);                                              // cycle 4
    check("ign_done", done, 1);
    check("ign_idx", class_idx, 3);
    check("ign_val", max_value, 768);
    input_vector = pk(0, 0, 0, 1000); start = 1'b1;
    @(negedge clk); start = 1'b0; input_vector = pk(5000, 0, 0, 0); // cycle 5
    check("b2b_busy", busy, 1);
    check("b2b_hold_val", max_value, 768);
    repeat (2) @(negedge clk);                                   // cycle 7
    check("b2b_nodone", done, 0);
    @(negedge clk);                                              // cycle 8
    check("b2b_done", done, 1);
    check("b2b_idx", class_idx, 3);
    check("b2b_val", max_value, 1000);
    @(negedge clk);
    check("b2b_pulse1", done, 0);

    // Asynchronous reset in the middle of a scan.
    input_vector = pk(9, 8, 7, 6); start = 1'b1;                 // cycle 0
    @(negedge clk); start = 1'b0;                                // cycle 1
    @(negedge clk);                                              // cycle 2
    reset = 1'b1;
    #1;
    check("mid_rst_idx", class_idx, 0);
    check("mid_rst_val", max_value, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_nodone", done, 0);
    end
    run("after_rst", pk(9, 8, 7, 6), 0, 9);

    // Random vectors, with boundary values mixed in often.
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0: v[i] = -32768;
          1: v[i] = 32767;
          2: v[i] = $urandom_range(0, 3) - 1;
          default: v[i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      ref_argmax(pk(v[0], v[1], v[2], v[3]), ridx, rval);
      run("rand", pk(v[0], v[1], v[2], v[3]), ridx, rval);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
